// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// dmem_pkg : state encoding and counter width shared by the data-memory responder
// Revision : 1.0
// ============================================================================
package dmem_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_ram.sv
`default_nettype none
// ============================================================================
// dmem_ram : DEPTH x 32 storage, byte-enabled synchronous write, registered read
// Revision : 1.0
// ============================================================================
module dmem_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Storage is deliberately left without reset; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// dmem_responder : valid/ready data-memory slave with programmable wait states
// Revision       : 1.0
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic              we_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic              accept;
    logic              access;
    logic              err;
    logic [31:0]       ram_rdata;

    assign accept = (state == IDLE) && req_valid;
    assign access = (state == WAIT) && (cnt == '0);
    assign err    = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= DEPTH_W);

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The RAM read is launched on the accepting edge so its registered output is
    // ready by the access edge; nothing can write the RAM in between.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                cnt     <= CNT_W'(WAIT_CYCLES);
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end else if ((state == WAIT) && (cnt != '0)) begin
                cnt <= cnt - 4'd1;
            end
            if (access) begin
                rsp_err   <= err;
                rsp_rdata <= (!we_q && !err) ? ram_rdata : 32'h0;
            end
        end
    end

    dmem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (access && we_q && !err),
        .be    (be_q),
        .waddr (addr_q[AW+1:2]),
        .wdata (wdata_q),
        .re    (accept),
        .raddr (req_addr[AW+1:2]),
        .rdata (ram_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// tb_dmem_responder : scoreboard bench; instance 0 uses WAIT_CYCLES=2, instance 1 uses 0
// Revision          : 1.0
// ============================================================================
module tb_dmem_responder;

    typedef struct {
        int          inst;
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n   [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be    [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    exp_t sb[$];
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 3 : 1;
        logic prev_v;

        dmem_responder #(
            .DEPTH       (64),
            .WAIT_CYCLES ((g == 0) ? 2 : 0)
        ) u_dut (
            .clk       (clk),
            .reset     (reset_n[g]),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_we    (req_we[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .req_be    (req_be[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_err   (rsp_err[g])
        );

        always @(negedge clk) begin
            if (!reset_n[g]) begin
                prev_v <= 1'b0;
            end else begin
                if (rsp_valid[g] && !prev_v) begin
                    if (sb.size() != 0 && sb[0].inst == g) begin
                        check("latency", 32'(cyc - sb[0].acc), 32'(LAT));
                    end else begin
                        total_cnt++;
                        $display("FAIL unexpected_rsp: inst %0d responded with no expected entry", g);
                    end
                end
                if (rsp_valid[g] && rsp_ready[g] && sb.size() != 0 && sb[0].inst == g) begin
                    check("rsp_rdata", rsp_rdata[g], sb[0].rdata);
                    check("rsp_err", 32'(rsp_err[g]), 32'(sb[0].err));
                    void'(sb.pop_front());
                end
                prev_v <= rsp_valid[g];
            end
        end
    end

    // Caller must be at a negedge; returns at the negedge after the accepting edge.
    task automatic do_req(input int i, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input logic [31:0] erd, input logic eerr,
                          input bit push, input bit keep, output int acc);
        exp_t e;
        int   t = 0;
        req_we[i]    = we;
        req_addr[i]  = addr;
        req_wdata[i] = wdata;
        req_be[i]    = be;
        req_valid[i] = 1'b1;
        while (!req_ready[i] && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready[i]) begin
            check("accept_timeout", 32'(req_ready[i]), 32'd1);
            req_valid[i] = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        acc = cyc;
        if (!keep) begin
            // Scramble the request bus; the accepted transaction must not notice.
            req_valid[i] = 1'b0;
            req_we[i]    = ~we;
            req_addr[i]  = ~addr;
            req_wdata[i] = ~wdata;
            req_be[i]    = ~be;
        end
        if (push) begin
            e.inst  = i;
            e.rdata = erd;
            e.err   = eerr;
            e.acc   = acc;
            sb.push_back(e);
        end
    endtask

    task automatic check_reset_state(input int i);
        check("rst_req_ready", 32'(req_ready[i]), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid[i]), 32'd0);
        check("rst_rsp_err", 32'(rsp_err[i]), 32'd0);
        check("rst_rsp_rdata", rsp_rdata[i], 32'd0);
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("drain_queue_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int acc;
        int prev_acc;
        int rel;
        int t;
        for (int i = 0; i < 2; i++) begin
            reset_n[i]   = 1'b1;
            req_valid[i] = 1'b0;
            req_we[i]    = 1'b0;
            req_addr[i]  = '0;
            req_wdata[i] = '0;
            req_be[i]    = '0;
            rsp_ready[i] = 1'b1;
        end
        #1;
        reset_n[0] = 1'b0;
        reset_n[1] = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state(0);
        check_reset_state(1);
        reset_n[0] = 1'b1;
        reset_n[1] = 1'b1;
        rel = cyc;

        // Full-word write then read back; first accept right after reset release
        do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 1, 0, acc);
        check("first_accept_edge", 32'(acc), 32'(rel + 1));
        do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1, 0, acc);

        // Partial byte-lane write
        do_req(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0, 1, 0, acc);
        do_req(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 32'h0, 1'b0, 1, 0, acc);
        do_req(0, 1'b0, 32'h20, 32'h0, 4'hF, 32'h11BB33DD, 1'b0, 1, 0, acc);

        // Error accesses must not disturb memory; be=0 write is a no-op
        do_req(0, 1'b1, 32'h00, 32'h0BADF00D, 4'hF, 32'h0, 1'b0, 1, 0, acc);
        do_req(0, 1'b0, 32'h02, 32'h0, 4'hF, 32'h0, 1'b1, 1, 0, acc);
        do_req(0, 1'b0, 32'h100, 32'h0, 4'hF, 32'h0, 1'b1, 1, 0, acc);
        do_req(0, 1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 1, 0, acc);
        do_req(0, 1'b1, 32'h03, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 1, 0, acc);
        do_req(0, 1'b0, 32'h00, 32'h0, 4'h0, 32'h0BADF00D, 1'b0, 1, 0, acc);
        do_req(0, 1'b1, 32'h10, 32'h12345678, 4'h0, 32'h0, 1'b0, 1, 0, acc);
        do_req(0, 1'b0, 32'h10, 32'h0, 4'h3, 32'hDEADBEEF, 1'b0, 1, 0, acc);
        drain();

        // Back-pressure: response held stable while rsp_ready is low
        rsp_ready[0] = 1'b0;
        do_req(0, 1'b0, 32'h20, 32'h0, 4'hF, 32'h11BB33DD, 1'b0, 1, 0, acc);
        t = 0;
        while (!rsp_valid[0] && t < 20) begin
            @(negedge clk);
            t++;
        end
        for (int k = 0; k < 5; k++) begin
            check("hold_rsp_valid", 32'(rsp_valid[0]), 32'd1);
            check("hold_rsp_rdata", rsp_rdata[0], 32'h11BB33DD);
            check("hold_rsp_err", 32'(rsp_err[0]), 32'd0);
            check("hold_req_ready", 32'(req_ready[0]), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 rsp_ready[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("idle_after_rsp_ready", 32'(req_ready[0]), 32'd1);
        check("no_rsp_after_ack", 32'(rsp_valid[0]), 32'd0);

        // Reset during WAIT aborts a pending write
        do_req(0, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 1, 0, acc);
        do_req(0, 1'b1, 32'h30, 32'h00000055, 4'hF, 32'h0, 1'b0, 0, 0, acc);
        #2 reset_n[0] = 1'b0;
        #1 check_reset_state(0);
        repeat (3) @(negedge clk);
        reset_n[0] = 1'b1;
        rel = cyc;
        do_req(0, 1'b0, 32'h30, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0, 1, 0, acc);
        check("accept_after_reset", 32'(acc), 32'(rel + 1));
        drain();

        // Zero wait states, req_valid held high, back-to-back accepts
        do_req(1, 1'b1, 32'h40, 32'h12345678, 4'hF, 32'h0, 1'b0, 1, 1, acc);
        prev_acc = acc;
        do_req(1, 1'b0, 32'h40, 32'h0, 4'hF, 32'h12345678, 1'b0, 1, 1, acc);
        check("b2b_spacing_1", 32'(acc - prev_acc), 32'd3);
        prev_acc = acc;
        do_req(1, 1'b0, 32'h41, 32'h0, 4'hF, 32'h0, 1'b1, 1, 1, acc);
        check("b2b_spacing_2", 32'(acc - prev_acc), 32'd3);
        prev_acc = acc;
        do_req(1, 1'b1, 32'h40, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0, 1, 1, acc);
        check("b2b_spacing_3", 32'(acc - prev_acc), 32'd3);
        prev_acc = acc;
        do_req(1, 1'b0, 32'h40, 32'h0, 4'hF, 32'h12345678, 1'b0, 1, 0, acc);
        check("b2b_spacing_4", 32'(acc - prev_acc), 32'd3);
        drain();

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, meaning the number of 32-bit words of storage (power of two, at least 4).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, meaning the added wait states per access (0..15).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset; 0 asserts.
REQ-005 The block SHALL have port req_valid  input  1  the initiator presents a request.
REQ-006 The block SHALL have port req_ready  output  1  the responder can accept a request.
REQ-007 The block SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-008 The block SHALL have port req_addr  input  32  byte address, taken from the datapath ALUResult.
REQ-009 The block SHALL have port req_wdata  input  32  write data, taken from the datapath WriteData.
REQ-010 The block SHALL have port req_be  input  4  byte enables; bit i enables byte lane [8i+7:8i].
REQ-011 The block SHALL have port rsp_valid  output  1  a response is available.
REQ-012 The block SHALL have port rsp_ready  input  1  the initiator accepts the response.
REQ-013 The block SHALL have port rsp_rdata  output  32  read data, delivered to the datapath ReadData.
REQ-014 The block SHALL have port rsp_err  output  1  the access was rejected.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-016 In IDLE, req_ready SHALL be 1; in all other states it SHALL be 0.
REQ-017 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1; on that edge the block SHALL capture we, addr, wdata and be, load the counter with WAIT_CYCLES and enter WAIT.
REQ-018 In WAIT, the counter SHALL decrement on each edge while nonzero; on the edge where it is 0, the block SHALL perform the access and enter RESP.
REQ-019 rsp_valid SHALL be 1 only in RESP, first appearing WAIT_CYCLES+1 cycles after the accepting edge.
REQ-020 rsp_rdata and rsp_err SHALL be registered and held stable throughout RESP, independent of rsp_ready.
REQ-021 RESP SHALL return to IDLE on the edge where rsp_ready is 1.
REQ-022 No new request SHALL be accepted in the RESP-to-IDLE cycle, so the minimum spacing between accepts is WAIT_CYCLES+3 cycles.
REQ-023 Error condition: an access SHALL be an error when req_addr[1:0] != 0, or when req_addr[31:2] >= DEPTH.
REQ-024 On an error, the block SHALL NOT modify memory and SHALL return rsp_err=1 and rsp_rdata=0.
REQ-025 A valid write SHALL update only the enabled byte lanes of word addr[31:2] and SHALL return rsp_rdata=0 and rsp_err=0.
REQ-026 A write with req_be=0 SHALL be a legal no-op.
REQ-027 A valid read SHALL return the full word regardless of be, with rsp_err=0.
REQ-028 The initiator's inputs SHALL be ignored outside IDLE; changes on req_* after acceptance SHALL have no effect.
REQ-029 With WAIT_CYCLES=0, latency SHALL be exactly 1 cycle to rsp_valid.

Reset
REQ-030 While reset=0, the block SHALL immediately force the state to IDLE, the counter to 0, rsp_valid=0, rsp_err=0 and rsp_rdata=0; req_ready SHALL be 1 once the state is IDLE.
REQ-031 A reset asserted during WAIT or RESP SHALL abort the transaction; a write not yet performed SHALL NOT occur.
REQ-032 Memory contents SHALL NOT be reset and are undefined until written.
REQ-033 The first accept SHALL be possible on the first rising edge after reset deasserts.

Structure
REQ-034 Shared package dmem_pkg SHALL hold the state enum type (IDLE, WAIT, RESP) and the counter width constant (4 bits).
REQ-035 A single sub-module dmem_ram SHALL provide DEPTH x 32 storage with a synchronous byte-enabled write port and a registered read port.
REQ-036 The FSM, the counter and the error check SHALL reside in dmem_responder.

Verification
REQ-037 Scenario 1: write addr 0x10, wdata 0xDEADBEEF, be 0xF, then read 0x10 -> the read returns rdata 0xDEADBEEF, err 0, and rsp_valid rises 3 cycles after each accept (WAIT_CYCLES=2).
REQ-038 Scenario 2: write word 0x20 = 0x11223344, then write 0x20 with wdata 0xAABBCCDD, be 0x5, then read 0x20 -> rdata 0x11BB33DD.
REQ-039 Scenario 3: read 0x02 (misaligned), then read 4*DEPTH (out of range) -> each returns err 1, rdata 0; a following read of 0x00 returns the previously written contents unchanged.
REQ-040 Scenario 4: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rdata and err stay stable and req_ready=0 throughout; rsp_ready=1 -> IDLE on the next edge.
REQ-041 Scenario 5: accept a write of 0x55 to 0x30, then assert reset during WAIT -> the block returns to IDLE; after reset, a read of 0x30 returns the old value, not 0x55.
REQ-042 Scenario 6: with WAIT_CYCLES=0, issue back-to-back requests with req_valid held at 1 and rsp_ready=1 -> accepts occur every 3 cycles with latency 1.
